// File: rtl/signal_conflict_monitor_if.sv
// Light-code bus between the intersection controller and its conflict monitor.
// The controller drives the light codes and the acknowledge; the monitor reports fault status.
interface signal_conflict_monitor_if;
  logic [1:0] H;
  logic [1:0] C;
  logic       ack;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
  logic [7:0] fault_count;

  modport master (output H, C, ack, input fault, fault_code, flash, fault_count);
  modport slave  (input H, C, ack, output fault, fault_code, flash, fault_count);
endinterface

// File: rtl/signal_conflict_monitor.sv
// Independent watchdog on the highway/country light codes: latches the first rule
// violation as a sticky fault and drives a flashing-red output until acknowledged.
module signal_conflict_monitor #(
  parameter int MIN_YELLOW    = 3,
  parameter int MIN_RED_CLEAR = 2,
  parameter int FLASH_HALF    = 4,
  parameter int CNT_W         = 4
) (
  input  logic                      clock,
  input  logic                      clear_n,
  signal_conflict_monitor_if.slave  mon
);

  localparam logic [1:0] LC_R = 2'b00;
  localparam logic [1:0] LC_Y = 2'b01;
  localparam logic [1:0] LC_G = 2'b10;
  localparam logic [1:0] LC_X = 2'b11;
  localparam int TMR_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] MIN_Y  = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MIN_RC = CNT_W'(MIN_RED_CLEAR);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) sat_inc = v;
    else                    sat_inc = v + CNT_W'(1);
  endfunction

  function automatic logic bad_step(input logic [1:0] p, input logic [1:0] n);
    return ((p == LC_G) && (n == LC_R)) || ((p == LC_R) && (n == LC_Y)) ||
           ((p == LC_Y) && (n == LC_G));
  endfunction

  logic [1:0]       prev_h_r, prev_c_r;
  logic [CNT_W-1:0] yel_h_r, yel_c_r, allred_r;
  logic             armed_r, fault_r, flash_r;
  logic [2:0]       code_r;
  logic [7:0]       count_r;
  logic [TMR_W-1:0] timer_r;

  logic             illegal_s, conflict_s, bad_step_s, short_y_s, early_g_s, viol_s;
  logic [2:0]       code_s;
  logic             fault_nxt_s, flash_nxt_s, armed_nxt_s;
  logic [2:0]       code_nxt_s;
  logic [7:0]       count_nxt_s;
  logic [TMR_W-1:0] timer_nxt_s;

  assign illegal_s  = (mon.H == LC_X) || (mon.C == LC_X);
  assign conflict_s = (mon.H != LC_R) && (mon.C != LC_R);
  assign bad_step_s = bad_step(prev_h_r, mon.H) || bad_step(prev_c_r, mon.C);
  assign short_y_s  = ((prev_h_r == LC_Y) && (mon.H == LC_R) && (yel_h_r < MIN_Y)) ||
                      ((prev_c_r == LC_Y) && (mon.C == LC_R) && (yel_c_r < MIN_Y));
  assign early_g_s  = (((prev_h_r == LC_R) && (mon.H == LC_G)) ||
                       ((prev_c_r == LC_R) && (mon.C == LC_G))) && (allred_r < MIN_RC);

  // Violation code of the current sample; lowest code wins, history checks need armed_r.
  always_comb begin
    code_s = 3'd0;
    if (illegal_s)                     code_s = 3'd1;
    else if (conflict_s)               code_s = 3'd2;
    else if (armed_r && bad_step_s)    code_s = 3'd3;
    else if (armed_r && short_y_s)     code_s = 3'd4;
    else if (armed_r && early_g_s)     code_s = 3'd5;
    else                               code_s = 3'd0;
  end

  assign viol_s = (code_s != 3'd0);

  // Fault latch, acknowledge and flash timer next-state.
  always_comb begin
    fault_nxt_s = fault_r;
    code_nxt_s  = code_r;
    count_nxt_s = count_r;
    flash_nxt_s = flash_r;
    timer_nxt_s = timer_r;
    armed_nxt_s = 1'b1;
    if (viol_s && (!fault_r || mon.ack)) begin
      fault_nxt_s = 1'b1;
      code_nxt_s  = code_s;
      count_nxt_s = (count_r == 8'hFF) ? count_r : count_r + 8'd1;
      flash_nxt_s = 1'b1;
      timer_nxt_s = {TMR_W{1'b0}};
    end else if (fault_r && mon.ack) begin
      fault_nxt_s = 1'b0;
      code_nxt_s  = 3'd0;
      flash_nxt_s = 1'b0;
      timer_nxt_s = {TMR_W{1'b0}};
      armed_nxt_s = 1'b0;
    end else if (fault_r) begin
      if (timer_r == TMR_LAST) begin
        timer_nxt_s = {TMR_W{1'b0}};
        flash_nxt_s = ~flash_r;
      end else begin
        timer_nxt_s = timer_r + TMR_W'(1);
      end
    end else begin
      flash_nxt_s = 1'b0;
      timer_nxt_s = {TMR_W{1'b0}};
    end
  end

  // History, run-length counters and fault state registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      prev_h_r <= LC_R;
      prev_c_r <= LC_R;
      yel_h_r  <= {CNT_W{1'b0}};
      yel_c_r  <= {CNT_W{1'b0}};
      allred_r <= {CNT_W{1'b0}};
      armed_r  <= 1'b0;
      fault_r  <= 1'b0;
      code_r   <= 3'd0;
      count_r  <= 8'd0;
      flash_r  <= 1'b0;
      timer_r  <= {TMR_W{1'b0}};
    end else begin
      prev_h_r <= mon.H;
      prev_c_r <= mon.C;
      yel_h_r  <= (mon.H == LC_Y) ? sat_inc(yel_h_r) : {CNT_W{1'b0}};
      yel_c_r  <= (mon.C == LC_Y) ? sat_inc(yel_c_r) : {CNT_W{1'b0}};
      allred_r <= ((mon.H == LC_R) && (mon.C == LC_R)) ? sat_inc(allred_r) : {CNT_W{1'b0}};
      armed_r  <= armed_nxt_s;
      fault_r  <= fault_nxt_s;
      code_r   <= code_nxt_s;
      count_r  <= count_nxt_s;
      flash_r  <= flash_nxt_s;
      timer_r  <= timer_nxt_s;
    end
  end

  assign mon.fault       = fault_r;
  assign mon.fault_code  = code_r;
  assign mon.flash       = flash_r;
  assign mon.fault_count = count_r;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Bench for signal_conflict_monitor: directed scenarios plus randomized light sequences
// checked against a history-based reference model.
module tb_signal_conflict_monitor;
  localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10, X = 2'b11;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  signal_conflict_monitor_if bus();

  signal_conflict_monitor dut (.clock(clock), .clear_n(clear_n), .mon(bus));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: full sample history, rules evaluated on it directly.
  logic [1:0] hist_h[$];
  logic [1:0] hist_c[$];
  bit m_armed, m_fault;
  int m_code, m_count, m_age;

  function automatic bit illegal_step(logic [1:0] p, logic [1:0] n);
    return (p == G && n == R) || (p == R && n == Y) || (p == Y && n == G);
  endfunction

  function automatic int yellow_run(bit road_c);
    int n = 0;
    for (int i = hist_h.size() - 1; i >= 0; i--) begin
      if ((road_c ? hist_c[i] : hist_h[i]) == Y) n++;
      else break;
    end
    return (n > 15) ? 15 : n;
  endfunction

  function automatic int allred_run();
    int n = 0;
    for (int i = hist_h.size() - 1; i >= 0; i--) begin
      if (hist_h[i] == R && hist_c[i] == R) n++;
      else break;
    end
    return (n > 15) ? 15 : n;
  endfunction

  function automatic int classify(logic [1:0] h, logic [1:0] c);
    logic [1:0] ph, pc;
    ph = (hist_h.size() == 0) ? R : hist_h[hist_h.size() - 1];
    pc = (hist_c.size() == 0) ? R : hist_c[hist_c.size() - 1];
    if (h == X || c == X) return 1;
    if (h != R && c != R) return 2;
    if (!m_armed) return 0;
    if (illegal_step(ph, h) || illegal_step(pc, c)) return 3;
    if ((ph == Y && h == R && yellow_run(1'b0) < 3) || (pc == Y && c == R && yellow_run(1'b1) < 3))
      return 4;
    if (((ph == R && h == G) || (pc == R && c == G)) && allred_run() < 2) return 5;
    return 0;
  endfunction

  function automatic bit m_flash();
    return m_fault && ((m_age / 4) % 2 == 0);
  endfunction

  task automatic model_reset();
    hist_h.delete();
    hist_c.delete();
    m_armed = 1'b0; m_fault = 1'b0; m_code = 0; m_count = 0; m_age = 0;
  endtask

  task automatic model_step(logic [1:0] h, logic [1:0] c, logic a);
    int code;
    bit next_armed;
    code = classify(h, c);
    next_armed = 1'b1;
    if (code != 0 && (!m_fault || a)) begin
      m_fault = 1'b1; m_code = code; m_age = 0;
      if (m_count < 255) m_count++;
    end else if (m_fault && a) begin
      m_fault = 1'b0; m_code = 0; m_age = 0; next_armed = 1'b0;
    end else if (m_fault) begin
      m_age++;
    end
    m_armed = next_armed;
    hist_h.push_back(h);
    hist_c.push_back(c);
    if (hist_h.size() > 32) begin
      void'(hist_h.pop_front());
      void'(hist_c.pop_front());
    end
  endtask

  task automatic step(logic [1:0] h, logic [1:0] c, logic a);
    @(negedge clock);
    bus.H = h; bus.C = c; bus.ack = a;
    @(posedge clock);
    model_step(h, c, a);
    #1;
  endtask

  task automatic test_reset();
    bus.H = R; bus.C = R; bus.ack = 1'b0;
    clear_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    n_checks++;
    if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0 || bus.flash !== 1'b0 || bus.fault_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: fault=%0b code=%0d flash=%0b count=%0d, required all 0",
               bus.fault, bus.fault_code, bus.flash, bus.fault_count);
    end
    clear_n = 1'b1;
  endtask

  task automatic test_legal_cycle();
    logic [1:0] th [7] = '{G, Y, R, R, R, R, G};
    logic [1:0] tc [7] = '{R, R, R, G, Y, R, R};
    int         tn [7] = '{5, 3, 2, 4, 3, 2, 1};
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < tn[r]; k++) begin
        step(th[r], tc[r], 1'b0);
        n_checks++;
        if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0) begin
          n_fail++;
          $display("FAIL legal_cycle row %0d: fault=%0b code=%0d, required 0/0", r, bus.fault, bus.fault_code);
        end
      end
    end
    n_checks++;
    if (bus.fault_count !== 8'd0) begin
      n_fail++;
      $display("FAIL legal_cycle count: got %0d, required 0", bus.fault_count);
    end
  endtask

  task automatic test_short_yellow();
    repeat (3) step(G, R, 1'b0);
    repeat (2) step(Y, R, 1'b0);
    n_checks++;
    if (bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL short_yellow pre: fault=%0b, required 0", bus.fault);
    end
    step(R, R, 1'b0);
    n_checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd4 || bus.flash !== 1'b1 || bus.fault_count !== 8'd1) begin
      n_fail++;
      $display("FAIL short_yellow latch: fault=%0b code=%0d flash=%0b count=%0d, required 1/4/1/1",
               bus.fault, bus.fault_code, bus.flash, bus.fault_count);
    end
    for (int i = 1; i <= 8; i++) begin
      step(R, R, 1'b0);
      n_checks++;
      if (bus.flash !== (((i / 4) % 2) == 0) || bus.fault_code !== 3'd4) begin
        n_fail++;
        $display("FAIL short_yellow flash cycle %0d: flash=%0b code=%0d, required %0b/4",
                 i, bus.flash, bus.fault_code, ((i / 4) % 2) == 0);
      end
    end
  endtask

  task automatic test_ack();
    step(R, R, 1'b1);
    n_checks++;
    if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0 || bus.flash !== 1'b0 || bus.fault_count !== 8'd1) begin
      n_fail++;
      $display("FAIL ack_clear: fault=%0b code=%0d flash=%0b count=%0d, required 0/0/0/1",
               bus.fault, bus.fault_code, bus.flash, bus.fault_count);
    end
    step(R, G, 1'b0);
    n_checks++;
    if (bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_rearm: fault=%0b code=%0d, required 0", bus.fault, bus.fault_code);
    end
    step(Y, Y, 1'b1);
    n_checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd2 || bus.fault_count !== 8'd2) begin
      n_fail++;
      $display("FAIL ack_conflict: fault=%0b code=%0d count=%0d, required 1/2/2",
               bus.fault, bus.fault_code, bus.fault_count);
    end
    step(X, R, 1'b1);
    n_checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd1 || bus.fault_count !== 8'd3 || bus.flash !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_reload: fault=%0b code=%0d count=%0d flash=%0b, required 1/1/3/1",
               bus.fault, bus.fault_code, bus.fault_count, bus.flash);
    end
    step(R, R, 1'b1);
    n_checks++;
    if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0) begin
      n_fail++;
      $display("FAIL ack_clear2: fault=%0b code=%0d, required 0/0", bus.fault, bus.fault_code);
    end
  endtask

  task automatic test_priority();
    step(X, G, 1'b0);
    n_checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd1 || bus.fault_count !== 8'd4) begin
      n_fail++;
      $display("FAIL priority: fault=%0b code=%0d count=%0d, required 1/1/4",
               bus.fault, bus.fault_code, bus.fault_count);
    end
    step(G, G, 1'b0);
    step(Y, Y, 1'b0);
    step(R, R, 1'b0);
    n_checks++;
    if (bus.fault_code !== 3'd1 || bus.fault_count !== 8'd4) begin
      n_fail++;
      $display("FAIL priority_sticky: code=%0d count=%0d, required 1/4", bus.fault_code, bus.fault_count);
    end
    step(R, R, 1'b1);
    n_checks++;
    if (bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL priority_clear: fault=%0b, required 0", bus.fault);
    end
  endtask

  task automatic test_short_clearance();
    repeat (2) step(G, R, 1'b0);
    repeat (3) step(Y, R, 1'b0);
    step(R, R, 1'b0);
    n_checks++;
    if (bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL clearance_pre: fault=%0b code=%0d, required 0", bus.fault, bus.fault_code);
    end
    step(R, G, 1'b0);
    n_checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd5 || bus.fault_count !== 8'd5) begin
      n_fail++;
      $display("FAIL clearance: fault=%0b code=%0d count=%0d, required 1/5/5",
               bus.fault, bus.fault_code, bus.fault_count);
    end
  endtask

  task automatic test_reset_mid_fault();
    repeat (5) step(R, G, 1'b0);
    n_checks++;
    if (bus.fault !== 1'b1 || bus.flash !== 1'b0) begin
      n_fail++;
      $display("FAIL midfault_pre: fault=%0b flash=%0b, required 1/0", bus.fault, bus.flash);
    end
    #2;
    clear_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0 || bus.flash !== 1'b0 || bus.fault_count !== 8'd0) begin
      n_fail++;
      $display("FAIL midfault_async: fault=%0b code=%0d flash=%0b count=%0d, required all 0",
               bus.fault, bus.fault_code, bus.flash, bus.fault_count);
    end
    clear_n = 1'b1;
    step(G, R, 1'b0);
    n_checks++;
    if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0) begin
      n_fail++;
      $display("FAIL midfault_unarmed: fault=%0b code=%0d, required 0/0", bus.fault, bus.fault_code);
    end
  endtask

  task automatic test_random();
    logic [1:0] h, c;
    logic a;
    int reps;
    for (int s = 0; s < 120; s++) begin
      h = ($urandom_range(0, 15) == 0) ? X : 2'($urandom_range(0, 2));
      c = ($urandom_range(0, 15) == 0) ? X : 2'($urandom_range(0, 2));
      if (h != R && $urandom_range(0, 3) != 0) c = R;
      reps = $urandom_range(1, 5);
      for (int k = 0; k < reps; k++) begin
        a = ($urandom_range(0, 4) == 0);
        step(h, c, a);
        n_checks++;
        if (bus.fault !== m_fault || bus.fault_code !== 3'(m_code) ||
            bus.flash !== m_flash() || bus.fault_count !== 8'(m_count)) begin
          n_fail++;
          $display("FAIL random seg %0d: got f=%0b code=%0d fl=%0b cnt=%0d, required f=%0b code=%0d fl=%0b cnt=%0d",
                   s, bus.fault, bus.fault_code, bus.flash, bus.fault_count,
                   m_fault, m_code, m_flash(), m_count);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_short_yellow();
    test_ack();
    test_priority();
    test_short_clearance();
    test_reset_mid_fault();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
